// File: rtl/cmp_pkg.sv
// Shared encodings for the comparator result monitor: result codes,
// FSM state codes and the one-hot flag decoder.
package cmp_pkg;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_GT   = 2'b01;
  localparam logic [1:0] RES_EQ   = 2'b10;
  localparam logic [1:0] RES_LT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRACK  = 2'b01,
    ST_LOCKED = 2'b10,
    ST_ERROR  = 2'b11
  } state_t;

  // Only meaningful for one-hot {x,y,z}; anything else maps to RES_NONE.
  function automatic logic [1:0] res_encode(input logic x, input logic y, input logic z);
    case ({x, y, z})
      3'b100:  return RES_GT;
      3'b010:  return RES_EQ;
      3'b001:  return RES_LT;
      default: return RES_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and soft clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_result_monitor.sv
// Monitors a 2-bit comparator's x/y/z flags: counts results, tracks equal runs
// to LOCKED, and flags malformed samples. Define CMP_CHECK_EN to cross-check flags against a/b.
module cmp_result_monitor
  import cmp_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [1:0]       a,
  input  logic [1:0]       b,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [1:0]       last_res,
  output logic             locked,
  output logic             err,
  output logic [1:0]       state
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

  state_t     state_q, state_nxt;
  logic [3:0] run_q, run_nxt;
  logic       accept, one_hot, agree, good, bad;
  logic [1:0] res;

  assign accept  = in_valid && !clear && (state_q != ST_ERROR);
  assign one_hot = ({x, y, z} == 3'b100) || ({x, y, z} == 3'b010) || ({x, y, z} == 3'b001);
  assign res     = res_encode(x, y, z);

`ifdef CMP_CHECK_EN
  assign agree = ({x, y, z} == {(a > b), (a == b), (a < b)});
`else
  logic unused_ab;
  assign unused_ab = ^{a, b};
  assign agree     = 1'b1;
`endif

  assign good = accept && one_hot && agree;
  assign bad  = accept && !(one_hot && agree);

  // The run saturates at LOCK_RUN, so further EQ samples keep LOCKED.
  always_comb begin
    run_nxt   = run_q;
    state_nxt = state_q;
    if (good) begin
      if (res == RES_EQ) begin
        run_nxt = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + 4'd1;
      end else begin
        run_nxt = 4'd0;
      end
      state_nxt = ((res == RES_EQ) && (run_nxt == LOCK_RUN)) ? ST_LOCKED : ST_TRACK;
    end else if (bad) begin
      state_nxt = ST_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= ST_IDLE;
      run_q    <= 4'd0;
      last_res <= RES_NONE;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      run_q   <= run_nxt;
      locked  <= (state_nxt == ST_LOCKED);
      if (good) last_res <= res;
      if (bad)  err      <= 1'b1;
    end
  end

  assign state = state_q;

  sat_counter #(.W(CNT_W)) u_gt (
    .clk(clk), .rst(rst), .clr(clear), .inc(good && (res == RES_GT)), .q(gt_cnt)
  );
  sat_counter #(.W(CNT_W)) u_eq (
    .clk(clk), .rst(rst), .clr(clear), .inc(good && (res == RES_EQ)), .q(eq_cnt)
  );
  sat_counter #(.W(CNT_W)) u_lt (
    .clk(clk), .rst(rst), .clr(clear), .inc(good && (res == RES_LT)), .q(lt_cnt)
  );

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: a default instance driven from a vector table
// and a CNT_W=2 / LOCK_LEN=1 instance driven by a short hand-written sequence.
module tb_cmp_result_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (CNT_W=8, LOCK_LEN=3)
  logic       rst, clear, in_valid, x, y, z;
  logic [1:0] a, b;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt;
  logic [1:0] last_res, state;
  logic       locked, err;

  // small instance (CNT_W=2, LOCK_LEN=1)
  logic       s_rst, s_clear, s_valid, s_x, s_y, s_z;
  logic [1:0] s_a, s_b;
  logic [1:0] s_gt, s_eq, s_lt;
  logic [1:0] s_last, s_state;
  logic       s_locked, s_err;

  cmp_result_monitor u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .x(x), .y(y), .z(z),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .last_res(last_res), .locked(locked), .err(err), .state(state)
  );

  cmp_result_monitor #(.CNT_W(2), .LOCK_LEN(1)) u_small (
    .clk(clk), .rst(s_rst), .clear(s_clear), .in_valid(s_valid),
    .a(s_a), .b(s_b), .x(s_x), .y(s_y), .z(s_z),
    .gt_cnt(s_gt), .eq_cnt(s_eq), .lt_cnt(s_lt),
    .last_res(s_last), .locked(s_locked), .err(s_err), .state(s_state)
  );

  // ---------------- vector records ----------------
  // expected word: {gt[7:0], eq[7:0], lt[7:0], last[1:0], locked, err, state[1:0]}
  typedef struct {
    logic       r, c, v;
    logic [1:0] a, b;
    logic [2:0] xyz;
    logic [29:0] e;
  } vec_t;

  function automatic logic [29:0] ex(input int g, input int q, input int l,
                                     input logic [1:0] last, input logic lk,
                                     input logic er, input logic [1:0] st);
    return {8'(g), 8'(q), 8'(l), last, lk, er, st};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic v,
                              input logic [1:0] va, input logic [1:0] vb,
                              input logic [2:0] xyz, input logic [29:0] e);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.a = va; t.b = vb; t.xyz = xyz; t.e = e;
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  logic [29:0] exp_q[$];
  logic [29:0] exp_s_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic check_word(input string tag, input logic [29:0] act, input logic [29:0] want);
    chk({tag, ".gt_cnt"},   act[29:22],         want[29:22]);
    chk({tag, ".eq_cnt"},   act[21:14],         want[21:14]);
    chk({tag, ".lt_cnt"},   act[13:6],          want[13:6]);
    chk({tag, ".last_res"}, {6'd0, act[5:4]},   {6'd0, want[5:4]});
    chk({tag, ".locked"},   {7'd0, act[3]},     {7'd0, want[3]});
    chk({tag, ".err"},      {7'd0, act[2]},     {7'd0, want[2]});
    chk({tag, ".state"},    {6'd0, act[1:0]},   {6'd0, want[1:0]});
  endtask

  // ---------------- drivers ----------------
  task automatic drive_main(input vec_t t, input int idx);
    logic [29:0] want;
    @(negedge clk);
    rst = t.r; clear = t.c; in_valid = t.v;
    a = t.a; b = t.b; {x, y, z} = t.xyz;
    exp_q.push_back(t.e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL main_queue_empty: got 0 entries expected 1");
    end else begin
      want = exp_q.pop_front();
      check_word($sformatf("main[%0d]", idx),
                 {gt_cnt, eq_cnt, lt_cnt, last_res, locked, err, state}, want);
    end
  endtask

  task automatic drive_small(input vec_t t, input int idx);
    logic [29:0] want;
    @(negedge clk);
    s_rst = t.r; s_clear = t.c; s_valid = t.v;
    s_a = t.a; s_b = t.b; {s_x, s_y, s_z} = t.xyz;
    exp_s_q.push_back(t.e);
    @(posedge clk);
    #1;
    if (exp_s_q.size() == 0) begin
      total++; bad++;
      $display("FAIL small_queue_empty: got 0 entries expected 1");
    end else begin
      want = exp_s_q.pop_front();
      check_word($sformatf("small[%0d]", idx),
                 {6'd0, s_gt, 6'd0, s_eq, 6'd0, s_lt, s_last, s_locked, s_err, s_state}, want);
    end
  endtask

  // ---------------- test ----------------
  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;

  vec_t tbl[$];
  vec_t stbl[$];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; a = 2'b00; b = 2'b00; x = 0; y = 0; z = 0;
    s_rst = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_a = 2'b00; s_b = 2'b00; s_x = 0; s_y = 0; s_z = 0;

    //                  r  c  v  a      b      xyz     gt eq lt last   lk err st
    tbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 3'b000, ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 1, 2'b01, 2'b00, GT,     ex(1, 0, 0, 2'b01, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 0, 2'b01, 2'b00, GT,     ex(1, 0, 0, 2'b01, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(1, 1, 0, 2'b10, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(1, 2, 0, 2'b10, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 2'b00, 3'b000, ex(1, 2, 0, 2'b10, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(1, 3, 0, 2'b10, 1, 0, 2'b10)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(1, 4, 0, 2'b10, 1, 0, 2'b10)));
    tbl.push_back(mk(0, 0, 1, 2'b01, 2'b10, LT,     ex(1, 4, 1, 2'b11, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(1, 5, 1, 2'b10, 0, 0, 2'b01)));
    // reset mid-run, then a fresh run must need three EQs again
    tbl.push_back(mk(1, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 1, 0, 2'b10, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 2, 0, 2'b10, 0, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 3, 0, 2'b10, 1, 0, 2'b10)));
    // malformed x=y=1, then samples in ERROR are ignored until clear
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, 3'b110, ex(0, 3, 0, 2'b10, 0, 1, 2'b11)));
    tbl.push_back(mk(0, 0, 1, 2'b01, 2'b00, GT,     ex(0, 3, 0, 2'b10, 0, 1, 2'b11)));
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 3'b000, ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 1, 2'b01, 2'b00, GT,     ex(1, 0, 0, 2'b01, 0, 0, 2'b01)));
    // clear wins over a same-cycle sample
    tbl.push_back(mk(0, 1, 1, 2'b01, 2'b00, GT,     ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    // no flag set is malformed too
    tbl.push_back(mk(0, 0, 1, 2'b01, 2'b00, 3'b000, ex(0, 0, 0, 2'b00, 0, 1, 2'b11)));
    tbl.push_back(mk(0, 1, 0, 2'b00, 2'b00, 3'b000, ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
`ifdef CMP_CHECK_EN
    tbl.push_back(mk(0, 0, 1, 2'b10, 2'b11, GT,     ex(0, 0, 0, 2'b00, 0, 1, 2'b11)));
`else
    tbl.push_back(mk(0, 0, 1, 2'b10, 2'b11, GT,     ex(1, 0, 0, 2'b01, 0, 0, 2'b01)));
`endif
    // rst dominates clear and in_valid
    tbl.push_back(mk(1, 1, 1, 2'b11, 2'b01, GT,     ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 1, 2'b11, 2'b01, GT,     ex(1, 0, 0, 2'b01, 0, 0, 2'b01)));

    // small instance: LOCK_LEN=1 locks on one EQ, 2-bit counters saturate at 3
    stbl.push_back(mk(1, 0, 0, 2'b00, 2'b00, 3'b000, ex(0, 0, 0, 2'b00, 0, 0, 2'b00)));
    stbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 1, 0, 2'b10, 1, 0, 2'b10)));
    stbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 2, 0, 2'b10, 1, 0, 2'b10)));
    stbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 3, 0, 2'b10, 1, 0, 2'b10)));
    stbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 3, 0, 2'b10, 1, 0, 2'b10)));
    stbl.push_back(mk(0, 0, 1, 2'b11, 2'b11, EQ,     ex(0, 3, 0, 2'b10, 1, 0, 2'b10)));
    stbl.push_back(mk(0, 0, 1, 2'b01, 2'b00, GT,     ex(1, 3, 0, 2'b01, 0, 0, 2'b01)));
    stbl.push_back(mk(0, 0, 1, 2'b10, 2'b10, EQ,     ex(1, 3, 0, 2'b10, 1, 0, 2'b10)));

    for (int i = 0; i < tbl.size(); i++) drive_main(tbl[i], i);

    for (int i = 0; i < stbl.size(); i++) drive_small(stbl[i], i);

    // Random idle gaps on the small instance must hold all state.
    for (int i = 0; i < 4; i++) begin
      vec_t t;
      t = mk(0, 0, 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), ex(1, 3, 0, 2'b10, 1, 0, 2'b10));
      drive_small(t, 100 + i);
    end

    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      total++; bad++;
      $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp_s_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each event counter.
REQ-002 Parameter LOCK_LEN, default 3: consecutive equal results needed to enter LOCKED; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous soft clear of counters, flags and state.
REQ-006 in_valid  input  1  qualifies a, b, x, y, z for the current cycle.
REQ-007 a  input  2  operand A as presented to the 2-bit comparator, {a1,a0}.
REQ-008 b  input  2  operand B as presented to the 2-bit comparator, {b1,b0}.
REQ-009 x  input  1  comparator flag, A>B.
REQ-010 y  input  1  comparator flag, A==B.
REQ-011 z  input  1  comparator flag, A<B.
REQ-012 gt_cnt  output  CNT_W  count of accepted A>B results.
REQ-013 eq_cnt  output  CNT_W  count of accepted A==B results.
REQ-014 lt_cnt  output  CNT_W  count of accepted A<B results.
REQ-015 last_res  output  2  last accepted result: 00 none, 01 GT, 10 EQ, 11 LT.
REQ-016 locked  output  1  high while the FSM is in LOCKED.
REQ-017 err  output  1  sticky error flag.
REQ-018 state  output  2  FSM state code: IDLE 00, TRACK 01, LOCKED 10, ERROR 11.

Function
REQ-019 All outputs SHALL be registered; a sample accepted at edge N is reflected on the outputs after edge N, i.e. one-cycle latency.
REQ-020 A sample is accepted only when in_valid=1, clear=0 and state is not ERROR.
REQ-021 A sample is well-formed when exactly one of x, y, z is 1; a malformed sample SHALL set err, move to ERROR, and leave counters and last_res unchanged.
REQ-022 On a well-formed sample, the matching counter SHALL increment and last_res SHALL update; counters saturate at 2^CNT_W-1 and never wrap.
REQ-023 An internal equal-run counter (4 bits) SHALL increment on each EQ sample, saturate at LOCK_LEN, and clear on any GT or LT sample.
REQ-024 Transitions: IDLE->TRACK on first well-formed sample; TRACK->LOCKED when the run counter reaches LOCK_LEN; LOCKED->TRACK on a GT or LT sample; any state->ERROR on a malformed or mismatched sample.
REQ-025 With LOCK_LEN=1, a single EQ sample from IDLE or TRACK SHALL enter LOCKED directly.
REQ-026 ERROR SHALL be left only by clear or rst; in_valid samples in ERROR are ignored.
REQ-027 clear SHALL take priority over in_valid in the same cycle: the sample is dropped and the block returns to the reset state.
REQ-028 Cycles with in_valid=0 SHALL hold all state; they do not break an equal run.

Reset
REQ-029 On rst=1 at a clock edge: counters 0, last_res 00, run counter 0, locked 0, err 0, state IDLE; rst dominates clear and in_valid.
REQ-030 rst asserted mid-run SHALL discard any partial equal run with no residual effect after release.

Configuration
REQ-031 Macro CMP_CHECK_EN: when defined, each well-formed sample SHALL also be checked against an internal compare of a and b, and any disagreement SHALL be treated as malformed (REQ-021); when undefined, a and b SHALL be ignored and only the one-hot check applies.

Structure
REQ-032 Package cmp_pkg SHALL hold the result encodings (RES_NONE/GT/EQ/LT) and the FSM state typedef with its codes.
REQ-033 Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) SHALL implement each of the three event counters.

Verification
REQ-034 Reset, then GT (a=01,b=00,x=1) -> next cycle gt_cnt=1, last_res=01, state=TRACK.
REQ-035 Three EQ samples (a=b=11, y=1) with LOCK_LEN=3 -> locked=1 after the third; an LT sample (a=01,b=10,z=1) -> locked=0, state=TRACK, lt_cnt=1.
REQ-036 Malformed sample x=1,y=1 -> err=1, state=11, counters unchanged; further valid samples ignored; clear -> state=IDLE, err=0.
REQ-037 Under CMP_CHECK_EN, a=10, b=11, x=1 -> err=1; without the macro, the same sample -> gt_cnt increments.
REQ-038 With CNT_W=2, five EQ samples -> eq_cnt holds at 3.
REQ-039 clear and in_valid asserted in the same cycle -> all counters 0 and state IDLE; the sample is not counted.
